// File: rtl/contador_decrescente.sv
// ============================================================================
// Module      : contador_decrescente
// Description : Presettable down counter/timer with terminal-count pulse and
//               optional auto-reload of the last loaded start value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_decrescente #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             done,
    output logic             busy
);

    localparam logic [0:0]       c_IDLE = 1'b0;
    localparam logic [0:0]       c_RUN  = 1'b1;
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_done;
    logic             r_busy;
    logic [WIDTH-1:0] w_count_next;
    logic             w_done_next;
    logic             w_terminal;

    // Terminal count only exists in RUN; IDLE ignores enable, so count can never underflow.
    assign w_terminal = (r_state == c_RUN) && enable && (r_count == c_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (load) begin
            w_next_state = (load_val != c_ZERO) ? c_RUN : c_IDLE;
        end else if (w_terminal && !auto_reload) begin
            w_next_state = c_IDLE;
        end
    end

    always_comb begin
        w_count_next = r_count;
        w_done_next  = 1'b0;
        if (load) begin
            w_count_next = load_val;
        end else if (w_terminal) begin
            w_done_next  = 1'b1;
            w_count_next = auto_reload ? r_reload : c_ZERO;
        end else if ((r_state == c_RUN) && enable) begin
            w_count_next = r_count - c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= c_ZERO;
            r_reload <= c_ZERO;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_done  <= w_done_next;
            r_busy  <= (w_next_state == c_RUN);
            if (load) begin
                r_reload <= load_val;
            end
        end
    end

    assign count = r_count;
    assign zero  = (r_count == c_ZERO);
    assign done  = r_done;
    assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_contador_decrescente.sv
// ============================================================================
// Module      : tb_contador_decrescente
// Description : Scoreboard bench: directed vectors queue expected outputs, a
//               monitor compares them one cycle after each driven edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_contador_decrescente;

    logic       clk;
    logic       reset;
    logic       load;
    logic [2:0] load_val;
    logic       enable;
    logic       auto_reload;
    logic [2:0] count;
    logic       zero;
    logic       done;
    logic       busy;

    typedef struct {
        int         cyc;
        string      name;
        logic [2:0] cnt;
        logic       dn;
        logic       bz;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;
    bit   stim_done;

    contador_decrescente #(.WIDTH(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count       (count),
        .zero        (zero),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one edge's worth of inputs; expected outputs land in the queue for the cycle after.
    task automatic step(input logic rs, input logic ld, input logic [2:0] lv,
                        input logic en, input logic ar, input string nm,
                        input logic [2:0] ec, input logic ed, input logic eb);
        exp_t e;
        @(negedge clk);
        reset       = rs;
        load        = ld;
        load_val    = lv;
        enable      = en;
        auto_reload = ar;
        e.cyc  = cyc + 1;
        e.name = nm;
        e.cnt  = ec;
        e.dn   = ed;
        e.bz   = eb;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        logic exp_zero;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                exp_zero = (e.cnt == 3'd0);
                n_cmp++;
                if (count !== e.cnt || zero !== exp_zero || done !== e.dn || busy !== e.bz) begin
                    n_bad++;
                    $display("FAIL %s: got count=%0d zero=%b done=%b busy=%b, want count=%0d zero=%b done=%b busy=%b",
                             e.name, count, zero, done, busy, e.cnt, exp_zero, e.dn, e.bz);
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        stim_done = 1'b0;
        reset = 1'b1; load = 1'b0; load_val = 3'd0; enable = 1'b0; auto_reload = 1'b0;

        // reset and idle-at-zero
        step(1, 0, 0, 0, 0, "rst1", 0, 0, 0);
        step(1, 0, 0, 0, 0, "rst2", 0, 0, 0);
        step(0, 0, 0, 1, 0, "idle_en1", 0, 0, 0);
        step(0, 0, 0, 1, 0, "idle_en2", 0, 0, 0);

        // countdown from 5, then no wrap below zero
        step(0, 1, 5, 0, 0, "ld5", 5, 0, 1);
        step(0, 0, 0, 1, 0, "dn4", 4, 0, 1);
        step(0, 0, 0, 1, 0, "dn3", 3, 0, 1);
        step(0, 0, 0, 1, 0, "dn2", 2, 0, 1);
        step(0, 0, 0, 1, 0, "dn1", 1, 0, 1);
        step(0, 0, 0, 1, 0, "dn0_done", 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, "nowrap", 0, 0, 0);

        // enable gaps
        step(0, 1, 3, 0, 0, "gap_ld3", 3, 0, 1);
        step(0, 0, 0, 1, 0, "gap_e1", 2, 0, 1);
        step(0, 0, 0, 0, 0, "gap_e0a", 2, 0, 1);
        step(0, 0, 0, 0, 0, "gap_e0b", 2, 0, 1);
        step(0, 0, 0, 1, 0, "gap_e1b", 1, 0, 1);
        step(0, 0, 0, 1, 0, "gap_done", 0, 1, 0);

        // auto-reload, then release it
        step(0, 1, 2, 0, 1, "ar_ld2", 2, 0, 1);
        step(0, 0, 0, 1, 1, "ar_1a", 1, 0, 1);
        step(0, 0, 0, 1, 1, "ar_rel_a", 2, 1, 1);
        step(0, 0, 0, 1, 1, "ar_1b", 1, 0, 1);
        step(0, 0, 0, 1, 1, "ar_rel_b", 2, 1, 1);
        step(0, 0, 0, 1, 0, "ar_off1", 1, 0, 1);
        step(0, 0, 0, 1, 0, "ar_off0", 0, 1, 0);

        // simultaneous load with enable / with terminal count
        step(0, 1, 4, 0, 0, "sim_ld4", 4, 0, 1);
        step(0, 1, 6, 1, 0, "sim_ld6_en", 6, 0, 1);
        step(0, 0, 0, 1, 0, "sim_5", 5, 0, 1);
        step(0, 0, 0, 1, 0, "sim_4", 4, 0, 1);
        step(0, 0, 0, 1, 0, "sim_3", 3, 0, 1);
        step(0, 0, 0, 1, 0, "sim_2", 2, 0, 1);
        step(0, 0, 0, 1, 0, "sim_1", 1, 0, 1);
        step(0, 1, 3, 1, 0, "ld_at_term", 3, 0, 1);

        // reset mid-run, then zero load
        step(1, 0, 0, 1, 0, "rst_mid", 0, 0, 0);
        step(0, 1, 0, 1, 0, "ld_zero", 0, 0, 0);
        step(0, 0, 0, 1, 0, "ld_zero_en", 0, 0, 0);

        // terminal held off by enable=0 at count 1
        step(0, 1, 1, 0, 0, "ld1", 1, 0, 1);
        step(0, 0, 0, 0, 0, "hold1", 1, 0, 1);
        step(0, 0, 0, 1, 0, "ld1_done", 0, 1, 0);
        step(0, 0, 0, 0, 0, "quiet", 0, 0, 0);

        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0 pending", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish within bound");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/contador_decrescente.md
Name: contador_decrescente

Overview:
Presettable down counter/timer. It is the decrementing counterpart of the team's 3-bit up counter. Software or an FSM loads a start value, and the block counts down toward zero while enabled. It pulses done on reaching terminal count and optionally auto-reloads, for use as a delay or interval generator.

Parameters:
WIDTH, 3, counter width in bits (valid range 2 to 16)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
load  input  1  load load_val into the counter and the reload register
load_val  input  WIDTH  start value captured on load
enable  input  1  count-enable; decrement only when high and running
auto_reload  input  1  on terminal count, reload the stored start value instead of stopping
count  output  WIDTH  current counter value (registered)
zero  output  1  high when count == 0 (combinational from count)
done  output  1  one-cycle pulse on terminal count (registered)
busy  output  1  high while in RUN state (registered)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising clk edge.
- Reset values: count=0, reload_reg=0, state=IDLE, done=0, busy=0. As a result, zero=1.
- States:
  - IDLE: count holds; enable is ignored.
  - RUN: count decrements by 1 on each edge with enable=1.
- Priority per edge: reset > load > terminal-count handling > decrement > hold.
- load=1, any state:
  - count and reload_reg take load_val on the next edge.
  - If load_val != 0, state goes to RUN. If load_val == 0, state goes to IDLE.
  - enable in the same cycle is ignored (no decrement).
  - done is 0 on that edge.
  - Load-to-visible latency is 1 cycle.
- RUN, enable=1, count > 1: count <= count - 1; done=0.
- RUN, enable=1, count == 1 (terminal), auto_reload sampled this cycle:
  - auto_reload=0: count <= 0, state goes to IDLE, busy <= 0, done <= 1.
  - auto_reload=1: count <= reload_reg, state stays RUN, done <= 1. count never shows 0 in this case.
- RUN, enable=0: count, state and busy hold; done=0.
- done is high for exactly one cycle per terminal event, aligned with the first cycle showing the new count.
- No underflow: count never wraps from 0 to 2^WIDTH-1. IDLE at 0 with enable=1 keeps count=0 and done=0.
- Arithmetic is modulo 2^WIDTH, but the RUN state guarantees count >= 1 before any subtract.
- reload_reg changes only on load or reset.
- Reset mid-run clears everything on that edge. No done pulse is generated by reset.
- load on the same edge as a terminal count: load wins and done stays 0.
- busy = (state == RUN); it updates on the same edge as the state change.

Test Plan:
1. Reset behaviour (WIDTH=3): hold reset=1 for 2 cycles -> count=0, zero=1, busy=0, done=0. Then pulse enable -> count stays 0.
2. Basic countdown with no wrap: load=1 with load_val=5, then enable=1 continuously.
   - Count sequence 5,4,3,2,1,0.
   - done=1 only in the cycle count becomes 0; busy falls in the same cycle.
   - Three more enabled cycles keep count=0 (never 7) with done=0.
3. Enable gaps: load 3, then enable pattern 1,0,0,1,1 -> count 3,2,2,2,1,0, with done in the last cycle only.
4. Auto-reload: auto_reload=1, load 2, enable held high.
   - Count sequence 2,1,2,1,2.
   - done pulses on each cycle showing the reloaded 2; zero never asserts; busy stays 1.
   - Drop auto_reload before the next terminal -> count reaches 0 and busy goes 0.
5. Simultaneous events:
   - At count=4 in RUN, assert load with load_val=6 and enable=1 -> next count=6 (no decrement).
   - At count=1 with enable=1, assert load with load_val=3 -> count=3, done=0.
6. Reset mid-operation and zero load:
   - At count=3 in RUN, assert reset -> count=0, busy=0, done=0.
   - Then load 0 -> count=0, busy=0, no done pulse.
